// File: rtl/tx_serial_pkg.sv
// Shared definitions for the serial transmitter arbiter slice.
// State codes, data width and 7E1/9600 baud timing constants.
package tx_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        PARTIDA = 2'd1,
        ESPERA  = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam int DADOS_W        = 7;
    localparam int TIMEOUT_PADRAO = 60000;
    localparam int CICLOS_BIT     = 5208;
    localparam int CICLOS_QUADRO  = 10 * CICLOS_BIT;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin search: first set request after the
// last served index, wrapping around.
module arbitro_rr #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pedido,
    input  logic [IDX_W-1:0] ultimo,
    output logic             valido,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] j;

    // Walk from the farthest candidate back to the nearest so the
    // nearest set bit after ultimo is the one left standing.
    always_comb begin
        valido = 1'b0;
        idx    = '0;
        j      = '0;
        for (int k = N; k >= 1; k--) begin
            j = IDX_W'((int'(ultimo) + k) % N);
            if (pedido[j]) begin
                valido = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/tx_serial_arbitro.sv
// Shares one 7E1 transmitter among N requesters: round-robin grant,
// single start pulse, completion on rising pronto, watchdog abort.
module tx_serial_arbitro
    import tx_serial_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         pedido,
    input  logic [DADOS_W*N-1:0] dados,
    output logic [N-1:0]         ack,
    output logic                 erro_timeout,
    output logic [N-1:0]         concedido,
    output logic                 ocupado,
    output logic                 tx_partida,
    output logic [DADOS_W-1:0]   tx_dados,
    input  logic                 tx_pronto,
    output logic [2:0]           db_estado
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(TIMEOUT_CICLOS - 1);
    localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(N - 1);
    localparam logic [N-1:0]     UM      = N'(1);

    estado_t            estado;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   ultimo;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valido;
    logic [WD_W-1:0]    wd;
    logic               pronto_ant;
    logic               pronto_sobe;
    logic [DADOS_W-1:0] caracter [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            caracter[i] = dados[DADOS_W*i +: DADOS_W];
        end
    end

    assign pronto_sobe = tx_pronto & ~pronto_ant;
    assign db_estado   = {1'b0, estado};

    arbitro_rr #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr (
        .pedido (pedido),
        .ultimo (ultimo),
        .valido (sel_valido),
        .idx    (sel_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            idx_r        <= '0;
            ultimo       <= IDX_ULT;
            wd           <= '0;
            pronto_ant   <= 1'b0;
            tx_dados     <= '0;
            concedido    <= '0;
            ack          <= '0;
            erro_timeout <= 1'b0;
            tx_partida   <= 1'b0;
            ocupado      <= 1'b0;
        end else begin
            pronto_ant   <= tx_pronto;
            ack          <= '0;
            erro_timeout <= 1'b0;
            tx_partida   <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (sel_valido) begin
                        idx_r      <= sel_idx;
                        tx_dados   <= caracter[sel_idx];
                        concedido  <= UM << sel_idx;
                        tx_partida <= 1'b1;
                        ocupado    <= 1'b1;
                        estado     <= PARTIDA;
                    end
                end
                PARTIDA: begin
                    wd     <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    // A real edge wins over a watchdog expiry in the same cycle.
                    if (pronto_sobe || wd == WD_LIM) begin
                        ack          <= concedido;
                        erro_timeout <= ~pronto_sobe;
                        concedido    <= '0;
                        estado       <= FIM;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                FIM: begin
                    ultimo  <= idx_r;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_serial_arbitro.sv
// Bench for tx_serial_arbitro: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_tx_serial_arbitro;

    localparam int N = 4;
    localparam int T = 100;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   pedido;
    logic [7*N-1:0] dados;
    logic           tx_pronto;
    logic [N-1:0]   ack;
    logic           erro_timeout;
    logic [N-1:0]   concedido;
    logic           ocupado;
    logic           tx_partida;
    logic [6:0]     tx_dados;
    logic [2:0]     db_estado;

    tx_serial_arbitro #(
        .N              (N),
        .TIMEOUT_CICLOS (T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pedido       (pedido),
        .dados        (dados),
        .ack          (ack),
        .erro_timeout (erro_timeout),
        .concedido    (concedido),
        .ocupado      (ocupado),
        .tx_partida   (tx_partida),
        .tx_dados     (tx_dados),
        .tx_pronto    (tx_pronto),
        .db_estado    (db_estado)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int grants[$];
    int waits[N];
    int tx_mode = 0;
    bit rand_tx = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nome, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d",
                     nome, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++)
            for (int b = 0; b < N; b++)
                if (b == (last + k) % N && p[b]) return b;
        return -1;
    endfunction

    function automatic logic [6:0] char_of(input int b);
        for (int i = 0; i < N; i++)
            if (i == b) return dados[7*i +: 7];
        return 7'h0;
    endfunction

    // Reference model: owner of the transmitter, cycles waited, end phase.
    int         m_owner;
    int         m_last;
    int         m_age;
    bit         m_fim;
    logic [6:0] m_char;
    logic       m_prev;
    logic [N-1:0] e_ack;
    logic       e_err;
    logic       e_partida;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_owner <= -1; m_last <= N - 1; m_age <= 0; m_fim <= 0;
            m_char <= '0; m_prev <= 0;
            e_ack <= '0; e_err <= 0; e_partida <= 0;
        end else begin
            m_prev    <= tx_pronto;
            e_ack     <= '0;
            e_err     <= 0;
            e_partida <= 0;
            if (m_fim) begin
                m_fim   <= 0;
                m_last  <= m_owner;
                m_owner <= -1;
            end else if (m_owner < 0) begin
                if (rr_pick(pedido, m_last) >= 0) begin
                    m_owner   <= rr_pick(pedido, m_last);
                    m_char    <= char_of(rr_pick(pedido, m_last));
                    m_age     <= 0;
                    e_partida <= 1;
                end
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (tx_pronto && !m_prev) begin
                m_fim <= 1;
                e_ack <= N'(1) << m_owner;
            end else if (m_age == T) begin
                m_fim <= 1;
                e_ack <= N'(1) << m_owner;
                e_err <= 1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    function automatic logic [2:0] est_esperado();
        if (m_owner < 0) return 3'd0;
        if (m_fim) return 3'd3;
        if (m_age == 0) return 3'd1;
        return 3'd2;
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            chk("partida", tx_partida, e_partida);
            chk("ack", ack, e_ack);
            chk("erro_timeout", erro_timeout, e_err);
            chk("ocupado", ocupado, m_owner >= 0);
            chk("db_estado", db_estado, est_esperado());
            if (m_owner < 0) chk("concedido_idle", concedido, 0);
            else if (!m_fim) chk("concedido", concedido, N'(1) << m_owner);
            if (m_owner >= 0) chk("tx_dados", tx_dados, m_char);
            if (tx_partida)
                for (int i = 0; i < N; i++)
                    if (concedido[i]) grants.push_back(i);
        end
    end

    // Transmitter stand-in: pulse, level, dead, or stale-high pronto.
    int tm, td;
    initial begin
        tx_pronto = 0;
        forever begin
            @(negedge clock);
            if (!reset && tx_partida) begin
                if (rand_tx) begin
                    tm = $urandom_range(0, 9);
                    tm = tm < 4 ? 0 : tm < 7 ? 1 : tm < 9 ? 3 : 2;
                end else begin
                    tm = tx_mode;
                end
                td = $urandom_range(3, 30);
                case (tm)
                    0: begin
                        tx_pronto = 0;
                        repeat (td) @(negedge clock);
                        tx_pronto = 1;
                        @(negedge clock);
                        tx_pronto = 0;
                    end
                    1: begin
                        tx_pronto = 0;
                        repeat (td) @(negedge clock);
                        tx_pronto = 1;
                    end
                    3: begin
                        tx_pronto = 1;
                        repeat (5) @(negedge clock);
                        tx_pronto = 0;
                        repeat (td) @(negedge clock);
                        tx_pronto = 1;
                    end
                    default: tx_pronto = 0;
                endcase
            end
        end
    end

    task automatic wait_partida(input int maxc, output int c);
        c = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (tx_partida) begin
                c = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_partida no start within %0d cycles", maxc);
    endtask

    task automatic wait_ack(input int maxc, output int c);
        c = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (ack != 0) begin
                c = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_ack no ack within %0d cycles", maxc);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1;
        #1;
        chk("rst_partida", tx_partida, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_concedido", concedido, 0);
        chk("rst_ack", ack, 0);
        chk("rst_erro", erro_timeout, 0);
        chk("rst_tx_dados", tx_dados, 0);
        chk("rst_db_estado", db_estado, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 0;
    endtask

    task automatic run_random(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if (pedido[i]) begin
                        checks++;
                        if (waits[i] > N - 1) begin
                            errors++;
                            $display("FAIL starvation req %0d waited %0d frames limit %0d",
                                     i, waits[i], N - 1);
                        end
                    end
                    waits[i] = 0;
                    if ($urandom_range(0, 1) == 0) pedido[i] = 0;
                    dados[7*i +: 7] = 7'($urandom);
                end else begin
                    if (ack != 0 && pedido[i]) waits[i]++;
                    if (!pedido[i] && $urandom_range(0, 7) == 0) begin
                        pedido[i] = 1;
                        waits[i] = 0;
                        dados[7*i +: 7] = 7'($urandom);
                    end else if (concedido[i] && $urandom_range(0, 15) == 0) begin
                        dados[7*i +: 7] = 7'($urandom);
                    end else if (concedido[i] && $urandom_range(0, 63) == 0) begin
                        pedido[i] = 0;
                    end
                end
            end
        end
    endtask

    int pc, ac;
    logic [N-1:0] acks[$];

    initial begin
        reset  = 1;
        pedido = '0;
        dados  = '0;
        repeat (3) @(negedge clock);
        reset = 0;

        // Single request
        do_reset();
        tx_mode = 0;
        dados[6:0] = 7'h35;
        pedido = 4'b0001;
        wait_partida(10, pc);
        chk("single_tx_dados", tx_dados, 7'h35);
        chk("single_parity", ^tx_dados, 0);
        wait_ack(100, ac);
        chk("single_ack", ack, 4'b0001);
        pedido = '0;
        repeat (4) @(negedge clock);

        // Contention from reset
        do_reset();
        grants.delete();
        acks.delete();
        dados = {7'h7F, 7'h7E, 7'h55, 7'h35};
        pedido = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(200, ac);
            acks.push_back(ack);
            pedido = pedido & ~ack;
        end
        chk("cont_nacks", acks.size(), 4);
        chk("cont_ack0", acks.size() > 0 ? acks[0] : 'x, 4'b0001);
        chk("cont_ack1", acks.size() > 1 ? acks[1] : 'x, 4'b0010);
        chk("cont_ack2", acks.size() > 2 ? acks[2] : 'x, 4'b0100);
        chk("cont_ack3", acks.size() > 3 ? acks[3] : 'x, 4'b1000);
        chk("cont_ngrants", grants.size(), 4);
        repeat (4) @(negedge clock);

        // Fairness with 0 and 2 held
        do_reset();
        grants.delete();
        pedido = 4'b0101;
        repeat (4) wait_ack(200, ac);
        pedido = '0;
        chk("fair_g0", grants.size() > 0 ? grants[0] : -1, 0);
        chk("fair_g1", grants.size() > 1 ? grants[1] : -1, 2);
        chk("fair_g2", grants.size() > 2 ? grants[2] : -1, 0);
        chk("fair_g3", grants.size() > 3 ? grants[3] : -1, 2);
        repeat (4) @(negedge clock);

        // Watchdog
        do_reset();
        tx_mode = 2;
        pedido = 4'b0001;
        wait_partida(10, pc);
        wait_ack(300, ac);
        chk("to_latency", ac - pc, T + 1);
        chk("to_ack", ack, 4'b0001);
        chk("to_erro", erro_timeout, 1);
        pedido = '0;
        tx_mode = 0;
        repeat (2) @(negedge clock);
        pedido = 4'b0010;
        wait_ack(100, ac);
        chk("to_next_ack", ack, 4'b0010);
        chk("to_next_erro", erro_timeout, 0);
        pedido = '0;
        repeat (4) @(negedge clock);

        // Reset during the start pulse
        do_reset();
        tx_mode = 2;
        pedido = 4'b0100;
        wait_partida(10, pc);
        #2 reset = 1;
        #1;
        chk("mid_rst_partida", tx_partida, 0);
        chk("mid_rst_concedido", concedido, 0);
        chk("mid_rst_ocupado", ocupado, 0);
        pedido = 4'b1111;
        tx_mode = 0;
        repeat (3) begin
            @(negedge clock);
            chk("mid_rst_no_ack", ack, 0);
        end
        reset = 0;
        wait_ack(100, ac);
        chk("mid_rst_winner", ack, 4'b0001);
        pedido = '0;
        repeat (4) @(negedge clock);

        // Stale level pronto
        do_reset();
        tx_mode = 1;
        pedido = 4'b0001;
        wait_ack(100, ac);
        pedido = '0;
        repeat (3) @(negedge clock);
        chk("stale_level_high", tx_pronto, 1);
        tx_mode = 3;
        pedido = 4'b0100;
        wait_partida(10, pc);
        wait_ack(100, ac);
        chk("stale_ack", ack, 4'b0100);
        chk("stale_late", (ac - pc) >= 9, 1);
        pedido = '0;
        repeat (4) @(negedge clock);

        // Random traffic
        do_reset();
        rand_tx = 1;
        for (int i = 0; i < N; i++) waits[i] = 0;
        run_random(3000);
        pedido = '0;
        rand_tx = 0;
        repeat (150) @(negedge clock);
        chk("end_idle", ocupado, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
